// File: rtl/idma_pkg.sv
`default_nettype none
// ============================================================================
// Module   : idma_pkg
// Purpose  : Shared types for the iDMA 2D split mid-end: the 1D back-end
//            burst request, the 2D (nd) request wrapper and the splitter
//            FSM state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package idma_pkg;

  localparam int unsigned ADDR_W = 64;
  localparam int unsigned REP_W  = 64;
  localparam int unsigned LEN_W  = 32;
  localparam int unsigned ID_W   = 4;

  // 1D back-end request. Only src_addr/dst_addr are rewritten by the
  // mid-end; every other field is carried through untouched.
  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [LEN_W-1:0]  length;
    logic [ADDR_W-1:0] src_addr;
    logic [ADDR_W-1:0] dst_addr;
    logic              decouple;
  } burst_req_t;

  // One dimension of repetition on top of the base burst.
  typedef struct packed {
    logic [REP_W-1:0]  reps;
    logic [ADDR_W-1:0] src_strides;
    logic [ADDR_W-1:0] dst_strides;
  } d_req_t;

  typedef struct packed {
    burst_req_t   burst_req;
    d_req_t [0:0] d_req;
  } nd_req_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } idma_2d_split_state_e;

endpackage
`default_nettype wire

// File: rtl/fifo_v3.sv
`default_nettype none
// ============================================================================
// Module   : fifo_v3
// Purpose  : Small synchronous FIFO (non fall-through). Push while full and
//            pop while empty are dropped; push and pop in the same cycle are
//            both applied.
// Ports    : clk_i, rst_ni (async, active-low), full_o, empty_o,
//            data_i/push_i (write side), data_o/pop_i (read side, data_o is
//            the current head).
// Revision : 1.0 - initial release
// ============================================================================
module fifo_v3 #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  output logic                  full_o,
  output logic                  empty_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  push_i,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  pop_i
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [CNT_W-1:0]      r_count;
  logic                  w_push;
  logic                  w_pop;

  assign full_o  = (r_count == CNT_W'(DEPTH));
  assign empty_o = (r_count == '0);
  assign data_o  = r_mem[r_rd_ptr];
  assign w_push  = push_i & ~full_o;
  assign w_pop   = pop_i & ~empty_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= data_i;
        // explicit wrap so non power-of-two depths also work
        r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/idma_2d_split_midend.sv
`default_nettype none
// ============================================================================
// Module   : idma_2d_split_midend
// Purpose  : Unrolls one 2D request (base burst + reps + src/dst strides)
//            into reps consecutive 1D bursts with stride-advanced addresses,
//            counts back-end completions per 2D job and pulses nd_rsp_valid_o
//            once per whole job, in order.
// Ports    : clk_i, rst_i (async, active-high)
//            nd_req_i / nd_req_valid_i / nd_req_ready_o       2D request in
//            burst_req_o / burst_req_valid_o / burst_req_ready_i 1D burst out
//            burst_rsp_valid_i   one pulse per completed 1D burst
//            nd_rsp_valid_o      one pulse per completed 2D job
//            busy_o              splitter issuing or jobs outstanding
// Revision : 1.0 - initial release
// ============================================================================
module idma_2d_split_midend #(
  parameter int unsigned AddrWidth    = 64,
  parameter int unsigned RepWidth     = 64,
  parameter int unsigned JobFifoDepth = 4,
  parameter type         nd_req_t     = idma_pkg::nd_req_t,
  parameter type         burst_req_t  = idma_pkg::burst_req_t
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  nd_req_t    nd_req_i,
  input  logic       nd_req_valid_i,
  output logic       nd_req_ready_o,
  output burst_req_t burst_req_o,
  output logic       burst_req_valid_o,
  input  logic       burst_req_ready_i,
  input  logic       burst_rsp_valid_i,
  output logic       nd_rsp_valid_o,
  output logic       busy_o
);

  import idma_pkg::*;

  idma_2d_split_state_e r_state;
  idma_2d_split_state_e w_state_next;

  // r_req doubles as the working address register: its src_addr/dst_addr
  // fields are advanced in place, so burst_req_o is simply r_req.
  burst_req_t           r_req;
  logic [AddrWidth-1:0] r_src_stride;
  logic [AddrWidth-1:0] r_dst_stride;
  logic [RepWidth-1:0]  r_rem_reps;
  logic [RepWidth-1:0]  r_done_cnt;
  logic                 r_nd_rsp_valid;

  logic [RepWidth-1:0]  w_eff_reps;
  logic [RepWidth-1:0]  w_head_reps;
  logic [RepWidth-1:0]  w_done_inc;
  logic                 w_fifo_full;
  logic                 w_fifo_empty;
  logic                 w_accept;
  logic                 w_burst_hs;
  logic                 w_rsp_hit;
  logic                 w_job_done;
  logic                 w_rst_n;

  // reps == 0 still moves the base burst once
  assign w_eff_reps = (nd_req_i.d_req[0].reps == '0) ? RepWidth'(1)
                                                     : nd_req_i.d_req[0].reps;

  always_comb begin
    w_state_next      = r_state;
    nd_req_ready_o    = 1'b0;
    burst_req_valid_o = 1'b0;
    case (r_state)
      IDLE: begin
        nd_req_ready_o = ~w_fifo_full;
        if (nd_req_valid_i && !w_fifo_full) w_state_next = ISSUE;
      end
      ISSUE: begin
        burst_req_valid_o = 1'b1;
        if (burst_req_ready_i && (r_rem_reps == RepWidth'(1))) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign w_accept    = nd_req_valid_i & nd_req_ready_o;
  assign w_burst_hs  = burst_req_valid_o & burst_req_ready_i;
  assign burst_req_o = r_req;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= IDLE;
      r_req        <= '0;
      r_src_stride <= '0;
      r_dst_stride <= '0;
      r_rem_reps   <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_req        <= nd_req_i.burst_req;
        r_src_stride <= nd_req_i.d_req[0].src_strides;
        r_dst_stride <= nd_req_i.d_req[0].dst_strides;
        r_rem_reps   <= w_eff_reps;
      end else if (w_burst_hs) begin
        // two's complement strides, modulo 2^AddrWidth
        r_req.src_addr <= r_req.src_addr + r_src_stride;
        r_req.dst_addr <= r_req.dst_addr + r_dst_stride;
        r_rem_reps     <= r_rem_reps - 1'b1;
      end
    end
  end

  // Completion tracking against the oldest outstanding job. Responses with
  // no job outstanding are dropped.
  assign w_rsp_hit  = burst_rsp_valid_i & ~w_fifo_empty;
  assign w_done_inc = r_done_cnt + 1'b1;
  assign w_job_done = w_rsp_hit & (w_done_inc == w_head_reps);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_done_cnt     <= '0;
      r_nd_rsp_valid <= 1'b0;
    end else begin
      r_nd_rsp_valid <= w_job_done;
      if (w_job_done)     r_done_cnt <= '0;
      else if (w_rsp_hit) r_done_cnt <= w_done_inc;
    end
  end

  assign w_rst_n = ~rst_i;

  fifo_v3 #(
    .DATA_WIDTH (RepWidth),
    .DEPTH      (JobFifoDepth)
  ) u_job_fifo (
    .clk_i   (clk_i),
    .rst_ni  (w_rst_n),
    .full_o  (w_fifo_full),
    .empty_o (w_fifo_empty),
    .data_i  (w_eff_reps),
    .push_i  (w_accept),
    .data_o  (w_head_reps),
    .pop_i   (w_job_done)
  );

  assign nd_rsp_valid_o = r_nd_rsp_valid;
  assign busy_o         = (r_state == ISSUE) | ~w_fifo_empty;

endmodule
`default_nettype wire

// File: tb/tb_idma_2d_split_midend.sv
`default_nettype none
// ============================================================================
// Module   : tb_idma_2d_split_midend
// Purpose  : Self-checking bench for idma_2d_split_midend. A queue-based
//            reference expands each accepted 2D job into its list of
//            expected bursts (base + i*stride) and tracks outstanding jobs
//            by their effective rep count; DUT outputs are compared every
//            cycle, #1 after the rising edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_idma_2d_split_midend;
  import idma_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_i;
  nd_req_t    nd_req_i;
  logic       nd_req_valid_i;
  logic       nd_req_ready_o;
  burst_req_t burst_req_o;
  logic       burst_req_valid_o;
  logic       burst_req_ready_i;
  logic       burst_rsp_valid_i;
  logic       nd_rsp_valid_o;
  logic       busy_o;

  idma_2d_split_midend #(
    .AddrWidth    (64),
    .RepWidth     (64),
    .JobFifoDepth (DEPTH)
  ) dut (
    .clk_i             (clk),
    .rst_i             (rst_i),
    .nd_req_i          (nd_req_i),
    .nd_req_valid_i    (nd_req_valid_i),
    .nd_req_ready_o    (nd_req_ready_o),
    .burst_req_o       (burst_req_o),
    .burst_req_valid_o (burst_req_valid_o),
    .burst_req_ready_i (burst_req_ready_i),
    .burst_rsp_valid_i (burst_rsp_valid_i),
    .nd_rsp_valid_o    (nd_rsp_valid_o),
    .busy_o            (busy_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // reference state
  logic [63:0] exp_src [$];
  logic [63:0] exp_dst [$];
  logic [31:0] exp_len [$];
  logic [63:0] job_reps [$];
  logic [63:0] done_cnt;
  int          unacked;
  bit          exp_nd_rsp;
  bit          prev_stall;
  burst_req_t  prev_burst;
  bit          rdy_rand;
  bit          rsp_auto;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    exp_src.delete(); exp_dst.delete(); exp_len.delete(); job_reps.delete();
    done_cnt   = '0;
    unacked    = 0;
    exp_nd_rsp = 1'b0;
    prev_stall = 1'b0;
  endtask

  // Check this cycle's outputs, advance the reference, then move one clock.
  task automatic step();
    bit          m_ready;
    logic [63:0] eff;
    m_ready = (exp_src.size() == 0) && (job_reps.size() < DEPTH);
    chk("nd_req_ready", {63'd0, nd_req_ready_o}, {63'd0, m_ready});
    chk("busy", {63'd0, busy_o}, {63'd0, (exp_src.size() != 0) || (job_reps.size() != 0)});
    chk("burst_valid", {63'd0, burst_req_valid_o}, {63'd0, exp_src.size() != 0});
    chk("nd_rsp_valid", {63'd0, nd_rsp_valid_o}, {63'd0, exp_nd_rsp});
    if (prev_stall) begin
      chk("stall_src", burst_req_o.src_addr, prev_burst.src_addr);
      chk("stall_dst", burst_req_o.dst_addr, prev_burst.dst_addr);
      chk("stall_len", {32'd0, burst_req_o.length}, {32'd0, prev_burst.length});
    end
    prev_stall = burst_req_valid_o && !burst_req_ready_i;
    prev_burst = burst_req_o;
    if (burst_req_valid_o && burst_req_ready_i && exp_src.size() != 0) begin
      chk("burst_src", burst_req_o.src_addr, exp_src.pop_front());
      chk("burst_dst", burst_req_o.dst_addr, exp_dst.pop_front());
      chk("burst_len", {32'd0, burst_req_o.length}, {32'd0, exp_len.pop_front()});
      unacked++;
    end
    exp_nd_rsp = 1'b0;
    if (burst_rsp_valid_i && job_reps.size() != 0) begin
      if (unacked > 0) unacked--;
      done_cnt = done_cnt + 1;
      if (done_cnt == job_reps[0]) begin
        void'(job_reps.pop_front());
        done_cnt   = '0;
        exp_nd_rsp = 1'b1;
      end
    end
    if (nd_req_valid_i && m_ready) begin
      eff = (nd_req_i.d_req[0].reps == 0) ? 64'd1 : nd_req_i.d_req[0].reps;
      for (logic [63:0] i = 0; i < eff; i++) begin
        exp_src.push_back(nd_req_i.burst_req.src_addr + i * nd_req_i.d_req[0].src_strides);
        exp_dst.push_back(nd_req_i.burst_req.dst_addr + i * nd_req_i.d_req[0].dst_strides);
        exp_len.push_back(nd_req_i.burst_req.length);
      end
      job_reps.push_back(eff);
    end
    @(posedge clk);
    #1;
    burst_req_ready_i = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    burst_rsp_valid_i = rsp_auto && (unacked > 0) && ($urandom_range(0, 1) == 1);
  endtask

  task automatic send_job(input logic [63:0] src, input logic [63:0] dst, input logic [31:0] len,
                          input logic [63:0] reps, input logic [63:0] ss, input logic [63:0] ds);
    bit acc;
    acc = 1'b0;
    nd_req_i                       = '0;
    nd_req_i.burst_req.src_addr    = src;
    nd_req_i.burst_req.dst_addr    = dst;
    nd_req_i.burst_req.length      = len;
    nd_req_i.burst_req.id          = 4'($urandom);
    nd_req_i.burst_req.decouple    = 1'($urandom);
    nd_req_i.d_req[0].reps         = reps;
    nd_req_i.d_req[0].src_strides  = ss;
    nd_req_i.d_req[0].dst_strides  = ds;
    nd_req_valid_i = 1'b1;
    for (int i = 0; i < 400 && !acc; i++) begin
      acc = nd_req_ready_o;
      step();
    end
    nd_req_valid_i = 1'b0;
    if (!acc) chk("accept_timeout", {63'd0, acc}, 64'd1);
  endtask

  task automatic drain(input int max_cycles);
    int left;
    for (int i = 0; i < max_cycles &&
         (exp_src.size() != 0 || (rsp_auto && job_reps.size() != 0)); i++) step();
    left = exp_src.size() + (rsp_auto ? job_reps.size() : 0);
    chk("drain", 64'(left), 64'd0);
  endtask

  task automatic pulse_rsp(input int n);
    for (int k = 0; k < n; k++) begin
      burst_rsp_valid_i = 1'b1;
      step();
      step();
    end
  endtask

  initial begin
    rst_i             = 1'b1;
    nd_req_i          = '0;
    nd_req_valid_i    = 1'b0;
    burst_req_ready_i = 1'b1;
    burst_rsp_valid_i = 1'b0;
    rdy_rand          = 1'b0;
    rsp_auto          = 1'b0;
    clear_model();

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_burst_valid", {63'd0, burst_req_valid_o}, 64'd0);
    chk("rst_nd_rsp", {63'd0, nd_rsp_valid_o}, 64'd0);
    chk("rst_busy", {63'd0, busy_o}, 64'd0);
    chk("rst_ready", {63'd0, nd_req_ready_o}, 64'd1);
    rst_i = 1'b0;
    step();

    // basic 3-rep job, then three completions
    send_job(64'h1000, 64'h8000, 32'd64, 64'd3, 64'h100, 64'h40);
    drain(20);
    pulse_rsp(3);
    step();

    // reps == 0 and reps == 1 both move exactly one burst
    send_job(64'h2000, 64'h3000, 32'd0, 64'd0, 64'h10, 64'h10);
    drain(10);
    send_job(64'h4000, 64'h5000, 32'd8, 64'd1, 64'h10, 64'h10);
    drain(10);
    pulse_rsp(2);

    // negative stride wrapping below zero
    send_job(64'h8, 64'h100, 32'd4, 64'd2, -64'sd16, 64'h0);
    chk("wrap_second_src", exp_src[exp_src.size()-1], 64'hFFFF_FFFF_FFFF_FFF8);
    drain(10);
    pulse_rsp(2);

    // randomized jobs with back-end stalls and random completion timing
    rdy_rand = 1'b1;
    rsp_auto = 1'b1;
    for (int j = 0; j < 12; j++) begin
      send_job({$urandom, $urandom}, {$urandom, $urandom},
               ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom,
               64'($urandom_range(0, 6)),
               {$urandom, $urandom}, {$urandom, $urandom});
    end
    drain(600);
    rdy_rand = 1'b0;
    rsp_auto = 1'b0;
    burst_req_ready_i = 1'b1;
    burst_rsp_valid_i = 1'b0;
    step();

    // fill the job FIFO with no completions; ready must drop and recover
    send_job(64'h10000, 64'h20000, 32'd16, 64'd2, 64'h20, 64'h20);
    send_job(64'h11000, 64'h21000, 32'd16, 64'd1, 64'h20, 64'h20);
    send_job(64'h12000, 64'h22000, 32'd16, 64'd3, 64'h20, 64'h20);
    send_job(64'h13000, 64'h23000, 32'd16, 64'd1, 64'h20, 64'h20);
    drain(20);
    chk("fifo_full_ready", {63'd0, nd_req_ready_o}, 64'd0);
    nd_req_valid_i = 1'b1;
    repeat (4) step();
    nd_req_valid_i = 1'b0;
    pulse_rsp(2);
    chk("fifo_ready_back", {63'd0, nd_req_ready_o}, 64'd1);
    pulse_rsp(5);
    step();

    // reset in the middle of an 8-rep job discards it
    send_job(64'h7000, 64'h9000, 32'd32, 64'd8, 64'h100, 64'h100);
    step();
    step();
    #2;
    rst_i = 1'b1;
    #1;
    chk("mid_rst_burst_valid", {63'd0, burst_req_valid_o}, 64'd0);
    chk("mid_rst_busy", {63'd0, busy_o}, 64'd0);
    chk("mid_rst_ready", {63'd0, nd_req_ready_o}, 64'd1);
    clear_model();
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    pulse_rsp(3);
    repeat (2) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/idma_2d_split_midend.md
# idma_2d_split_midend

Mid-end stage sitting directly downstream of the 64-bit register front-end's request arbiter and upstream of the 1D iDMA back-end. It accepts one 2D request (a base 1D burst, a repetition count and source/destination strides) per handshake and unrolls it into `reps` consecutive 1D bursts with stride-advanced addresses. It also counts back-end completions per 2D job and signals the end of each whole 2D job in order, and drives the mid-end busy bit reported to the status registers.

## Interface
- `AddrWidth`, default 64: width of src/dst addresses and strides.
- `RepWidth`, default 64: width of the repetition counter.
- `JobFifoDepth`, default 4: number of 2D jobs that may have bursts outstanding at the back-end.
- `nd_req_t`, default logic: 2D request type; fields used are `burst_req`, `d_req[0].reps`, `d_req[0].src_strides` and `d_req[0].dst_strides`.
- `burst_req_t`, default logic: 1D back-end request type; fields used are `src_addr`, `dst_addr` and `length`, all other fields passed through.
- `clk_i` input 1: the single clock.
- `rst_i` input 1: asynchronous, active-high reset.
- `nd_req_i` input nd_req_t: 2D request from the front-end.
- `nd_req_valid_i` input 1 / `nd_req_ready_o` output 1: 2D request handshake.
- `burst_req_o` output burst_req_t: 1D request to the back-end.
- `burst_req_valid_o` output 1 / `burst_req_ready_i` input 1: 1D request handshake.
- `burst_rsp_valid_i` input 1: one-cycle pulse, one per completed 1D burst, in issue order.
- `nd_rsp_valid_o` output 1: one-cycle pulse, one per completed 2D job.
- `busy_o` output 1: mid-end busy flag.

## Operation
- FSM with two states:
  - IDLE: `nd_req_ready_o = !job_fifo_full`.
  - ISSUE: `nd_req_ready_o = 0`.
- On acceptance:
  - latch the request into the working registers;
  - set `rem_reps` to `reps`, with `reps == 0` treated as 1;
  - push the effective reps into the job FIFO;
  - go to ISSUE.
- In ISSUE:
  - `burst_req_valid_o = 1`.
  - `burst_req_o` is the latched `burst_req` with `src_addr` and `dst_addr` replaced by the current working addresses.
  - `burst_req_o` and `burst_req_valid_o` are held stable until the handshake.
- On each burst handshake:
  - add the src stride to `cur_src` and the dst stride to `cur_dst`;
  - decrement `rem_reps`.
- Stride arithmetic:
  - strides are two's complement;
  - the add is modulo 2^AddrWidth, so wrap-around is silent.
- When the handshake occurs with `rem_reps == 1`, go to IDLE.
- `length == 0` bursts are forwarded unchanged.
- Completion tracking:
  - `done_cnt` (RepWidth bits) counts `burst_rsp_valid_i` pulses against the reps value at the job FIFO head.
  - When a pulse brings `done_cnt` to the head reps value: pop the FIFO, clear `done_cnt`, and pulse `nd_rsp_valid_o` on the next cycle.
- Simultaneous events:
  - A push and a pop in the same cycle are both applied.
  - A burst response that arrives while the job FIFO is empty is ignored.
- `busy_o = (state == ISSUE) | !job_fifo_empty`.
- Reset values:
  - state IDLE;
  - all counters and working registers zero;
  - job FIFO empty;
  - `burst_req_valid_o = 0`, `nd_rsp_valid_o = 0`, `busy_o = 0`;
  - `nd_req_ready_o = 1`.
- Reset mid-operation discards everything in flight; no `nd_rsp_valid_o` is emitted for discarded jobs.

## Timing
- A 2D request accepted in cycle N gives the first `burst_req_valid_o` in cycle N+1.
- With `burst_req_ready_i` held high, bursts issue at one per cycle, in cycles N+1 … N+reps.
- After the last burst handshake there is one IDLE cycle before the next 2D request can be accepted. Throughput is reps+1 cycles per job.
- `nd_rsp_valid_o` goes high exactly one cycle after the final matching `burst_rsp_valid_i`.
- There is no combinational path from `burst_req_ready_i` to `nd_req_ready_o` or from `burst_rsp_valid_i` to `nd_rsp_valid_o`.

## Structure
- The FSM state enum (IDLE, ISSUE) goes in the shared `idma_pkg` as `idma_2d_split_state_e`.
- The job FIFO is the common-cells `fifo_v3` (element width RepWidth, depth JobFifoDepth) and is the only sub-module.
- Address adders, the reps counter and the completion counter are local logic.

## Test plan
- reps=3, src=0x1000, dst=0x8000, sstride=0x100, dstride=0x40, ready high -> bursts with src 0x1000/0x1100/0x1200 and dst 0x8000/0x8040/0x8080 in cycles N+1..N+3; three response pulses -> one `nd_rsp_valid_o` one cycle after the third pulse.
- reps=0, then reps=1 -> each job issues exactly one burst and produces one `nd_rsp_valid_o`.
- Negative stride -0x10 from src 0x8 -> second burst src 0xFFFF_FFFF_FFFF_FFF8 (wrap).
- Random `burst_req_ready_i` stalls -> `burst_req_o` stable while valid and not ready; burst count equals reps.
- JobFifoDepth=4, four 2D jobs issued with no responses -> `nd_req_ready_o` low after the fourth acceptance; one job's responses complete -> ready returns; `nd_rsp_valid_o` pulses are in job order.
- `rst_i` asserted during ISSUE of a reps=8 job -> `burst_req_valid_o = 0`, `busy_o = 0` and `nd_req_ready_o = 1` immediately; no `nd_rsp_valid_o` afterwards.
